match_controller: RTL and testbench

- Parametrised successor to the sniffer's single-pattern controller.
- Pops words from the input FIFO, loads them into a bank of NUM_PAT pattern comparators, and waits a fixed comparator latency.
- On any hit, writes the word plus the lowest matching pattern index into capture memory.
- Sits between the input FIFO, the comparator bank and the capture RAM; adds multi-pattern priority, per-packet hit counting, and wrap/stop overflow modes.

---
 rtl/match_controller_pkg.sv | 18 +
 rtl/match_controller_prio_enc.sv | 25 ++
 rtl/match_controller.sv | 118 +++++++++++
 tb/tb_match_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_controller_pkg.sv
// Shared types for the packet match controller and its helpers.
// FSM encoding plus the pattern-index and hit-counter widths.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    EVAL,
    WRITE,
    DONE,
    HALT
  } state_t;

  localparam int PAT_IDX_W = 4;
  localparam int HITS_W    = 8;

endpackage

// File: rtl/match_controller_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
// Bit 0 has the highest priority.
module prio_enc
  import match_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_vec,
  output logic [PAT_IDX_W-1:0] o_idx,
  output logic                 o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = PAT_IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_controller.sv
// FIFO -> comparator bank -> capture RAM controller.
// Multi-pattern priority, per-packet hit count, wrap/stop capture.
module match_controller
  import match_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_PAT = 4,
  parameter int CMP_LAT = 2,
  parameter int ADDR_W  = 8,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        fifo_empty,
  input  logic [DATA_W:0]             fifo_data,
  output logic                        fifo_rdreq,
  output logic                        cmp_load,
  output logic [DATA_W-1:0]           cmp_data,
  input  logic [NUM_PAT-1:0]          match_vec,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W+PAT_IDX_W-1:0] mem_wdata,
  output logic [HITS_W-1:0]           pkt_hits,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  state_t               r_state;
  logic [2:0]           r_cnt;
  logic                 r_eop;
  logic [PAT_IDX_W-1:0] w_idx;
  logic                 w_hit;

  prio_enc #(
    .N(NUM_PAT)
  ) u_prio (
    .i_vec  (match_vec),
    .o_idx  (w_idx),
    .o_valid(w_hit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_eop      <= 1'b0;
      fifo_rdreq <= 1'b0;
      cmp_load   <= 1'b0;
      cmp_data   <= '0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pkt_hits   <= '0;
      overflow   <= 1'b0;
    end else begin
      fifo_rdreq <= 1'b0;
      cmp_load   <= 1'b0;
      mem_wr     <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (r_state == DONE && r_eop) pkt_hits <= '0;
          if (!fifo_empty) begin
            fifo_rdreq <= 1'b1;
            r_state    <= POP;
          end else begin
            r_state <= IDLE;
          end
        end
        POP: begin
          cmp_data <= fifo_data[DATA_W-1:0];
          r_eop    <= fifo_data[DATA_W];
          cmp_load <= 1'b1;
          r_cnt    <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 3'(CMP_LAT - 1)) r_state <= EVAL;
          else r_cnt <= r_cnt + 3'd1;
        end
        EVAL: begin
          if (w_hit) begin
            mem_wr    <= 1'b1;
            mem_wdata <= {w_idx, cmp_data};
            r_state   <= WRITE;
          end else begin
            r_state <= DONE;
          end
        end
        WRITE: begin
          if (pkt_hits != '1) pkt_hits <= pkt_hits + HITS_W'(1);
          if (mem_addr != '1) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            r_state  <= DONE;
          end else if (WRAP_EN || clr_ovf) begin
            mem_addr <= '0;
            r_state  <= DONE;
          end else begin
            overflow <= 1'b1;
            r_state  <= HALT;
          end
        end
        HALT: begin
          if (clr_ovf) begin
            pkt_hits <= '0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A clear coinciding with a write lets the write use the old address.
      if (clr_ovf) begin
        overflow <= 1'b0;
        mem_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: wrap instance A and stop instance B.
// Directed vectors; expected writes queued at issue, popped by a monitor.
module tb_match_controller;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]    addr;
    logic [DW+3:0] wdata;
  } wr_t;

  wr_t expa[$];
  wr_t expb[$];
  wr_t me;

  logic [DW:0] fa_mem [0:511];
  logic [3:0]  pa_mem [0:511];
  int          wa = 0;
  int          ra = 0;
  logic [7:0]  sr_a = '0;
  int          moff = 3;
  logic [1:0]  na = '0;

  logic          fe_a, rd_a, ld_a, wr_a, ov_a, clr_a;
  logic [DW:0]   fd_a;
  logic [DW-1:0] cd_a;
  logic [3:0]    mv_a;
  logic [1:0]    ad_a;
  logic [DW+3:0] wd_a;
  logic [7:0]    ph_a;

  assign fe_a = (ra == wa);
  assign fd_a = (ra < wa) ? fa_mem[ra] : '0;
  assign mv_a = (ra > 0 && sr_a[moff-1]) ? pa_mem[ra-1] : 4'h0;

  always @(posedge clk) if (rd_a) ra <= ra + 1;
  always @(posedge clk) sr_a <= {sr_a[6:0], ld_a};

  match_controller #(
    .DATA_W(DW), .NUM_PAT(4), .CMP_LAT(3), .ADDR_W(2), .WRAP_EN(1'b1)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .fifo_empty(fe_a), .fifo_data(fd_a),
    .fifo_rdreq(rd_a), .cmp_load(ld_a), .cmp_data(cd_a),
    .match_vec(mv_a), .mem_wr(wr_a), .mem_addr(ad_a),
    .mem_wdata(wd_a), .pkt_hits(ph_a), .overflow(ov_a), .clr_ovf(clr_a)
  );

  logic [DW:0] fb_mem [0:15];
  int          wb = 0;
  int          rb = 0;

  logic          fe_b, rd_b, ld_b, wr_b, ov_b, clr_b;
  logic [DW:0]   fd_b;
  logic [DW-1:0] cd_b;
  logic [3:0]    mv_b;
  logic [1:0]    ad_b;
  logic [DW+3:0] wd_b;
  logic [7:0]    ph_b;

  assign fe_b = (rb == wb);
  assign fd_b = (rb < wb) ? fb_mem[rb] : '0;
  assign mv_b = 4'hF;

  always @(posedge clk) if (rd_b) rb <= rb + 1;

  match_controller #(
    .DATA_W(DW), .NUM_PAT(4), .CMP_LAT(2), .ADDR_W(2), .WRAP_EN(1'b0)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .fifo_empty(fe_b), .fifo_data(fd_b),
    .fifo_rdreq(rd_b), .cmp_load(ld_b), .cmp_data(cd_b),
    .match_vec(mv_b), .mem_wr(wr_b), .mem_addr(ad_b),
    .mem_wdata(wd_b), .pkt_hits(ph_b), .overflow(ov_b), .clr_ovf(clr_b)
  );

  always @(negedge clk) begin
    if (wr_a) begin
      checks++;
      if (expa.size() == 0) begin
        errors++;
        $display("FAIL wr_a unexpected: addr=%0d wdata=%h", ad_a, wd_a);
      end else begin
        me = expa.pop_front();
        if ({ad_a, wd_a} !== me) begin
          errors++;
          $display("FAIL wr_a: got addr=%0d wdata=%h exp addr=%0d wdata=%h",
                   ad_a, wd_a, me.addr, me.wdata);
        end
      end
    end
    if (wr_b) begin
      checks++;
      if (expb.size() == 0) begin
        errors++;
        $display("FAIL wr_b unexpected: addr=%0d wdata=%h", ad_b, wd_b);
      end else begin
        me = expb.pop_front();
        if ({ad_b, wd_b} !== me) begin
          errors++;
          $display("FAIL wr_b: got addr=%0d wdata=%h exp addr=%0d wdata=%h",
                   ad_b, wd_b, me.addr, me.wdata);
        end
      end
    end
    if ((rd_a && fe_a) || (rd_b && fe_b)) begin
      errors++;
      $display("FAIL underflow: rd_a=%0b rd_b=%0b while empty, exp no read",
               rd_a, rd_b);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_a(input logic [DW-1:0] w, input logic eop,
                        input logic [3:0] pat, input int idx);
    fa_mem[wa] = {eop, w};
    pa_mem[wa] = pat;
    if (idx >= 0) begin
      expa.push_back({na, 4'(idx), w});
      na = na + 2'd1;
    end
    wa++;
  endtask

  task automatic push_b(input logic [DW-1:0] w, input logic eop,
                        input int a);
    fb_mem[wb] = {eop, w};
    expb.push_back({2'(a), 4'd0, w});
    wb++;
  endtask

  task automatic wait_wr_a(input string nm);
    int n = 0;
    while (!wr_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, wr_a, 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((expa.size() != 0 || expb.size() != 0 || ra != wa || rb != wb)
           && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    chk(nm, 64'(expa.size() + expb.size() + (wa - ra) + (wb - rb)), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    n_rst = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdreq", rd_a, 0);
    chk("rst_load", ld_a, 0);
    chk("rst_wr", wr_a, 0);
    chk("rst_addr", ad_a, 0);
    chk("rst_hits", ph_a, 0);
    chk("rst_ovf", ov_b, 0);
    n_rst = 1'b1;
    @(negedge clk);

    push_a(32'h0000ABCD, 1'b1, 4'b0100, 2);
    wait_wr_a("t1_wr");
    @(negedge clk);
    chk("t1_hits_done", ph_a, 1);
    @(negedge clk);
    chk("t1_hits_clr", ph_a, 0);

    push_a(32'h12345678, 1'b1, 4'b1010, 1);
    drain("t2_drain");

    moff = 2;
    push_a(32'h00000055, 1'b1, 4'b1111, -1);
    drain("t3_early");
    moff = 3;
    push_a(32'h00000077, 1'b1, 4'b1000, 3);
    drain("t3_ontime");

    chk("pre_clr_addr", ad_a, 3);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("clr_addr_a", ad_a, 0);
    na = 2'd0;
    for (int i = 0; i < 5; i++)
      push_a(32'hC0DE0000 + i, i == 4, 4'b0001, 0);
    drain("wrap_drain");

    for (int i = 0; i < 300; i++)
      push_a(32'h10000000 + i, i == 299, 4'b0011, 0);
    n = 0;
    while (ra != wa && n < 5000) begin
      @(negedge clk);
      n++;
    end
    wait_wr_a("sat_wr");
    @(negedge clk);
    chk("sat_hits", ph_a, 255);
    @(negedge clk);
    chk("sat_clr", ph_a, 0);
    drain("sat_drain");

    for (int i = 0; i < 5; i++)
      push_b(32'hB0000000 + i, i == 4, i % 4);
    n = 0;
    while (!ov_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_set", ov_b, 1);
    chk("ovf_addr_hold", ad_b, 3);
    repeat (20) @(negedge clk);
    chk("halt_no_pop", rb, 4);
    chk("halt_hits", ph_b, 4);
    chk("halt_pending", expb.size(), 1);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("clr_ovf_b", ov_b, 0);
    chk("clr_addr_b", ad_b, 0);
    chk("clr_hits_b", ph_b, 0);
    drain("b_drain");

    push_a(32'h0000DEAD, 1'b1, 4'b0001, -1);
    n = 0;
    while (!ld_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_load_seen", ld_a, 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_load", ld_a, 0);
    chk("mid_rst_cdata", cd_a, 0);
    chk("mid_rst_addr", ad_a, 0);
    chk("mid_rst_wr", wr_a, 0);
    chk("mid_rst_rdreq", rd_a, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_addr", ad_a, 0);
    chk("post_rst_queue", expa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
